// File: rtl/branch_predictor.sv
// Fetch next-PC generator: direct-mapped BTB with 2-bit counters, execute-stage
// resolution, stall-tolerant redirect and optional perf counters (BP_STATS_EN).
module branch_predictor #(
    parameter int unsigned ENTRIES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_f,
    input  logic        stall_f,
    output logic [31:0] pc_next,
    output logic        pred_taken_f,
    output logic [31:0] pred_target_f,
    input  logic        update_valid_e,
    input  logic        is_branch_e,
    input  logic        taken_e,
    input  logic [31:0] pc_e,
    input  logic [31:0] target_e,
    input  logic        pred_taken_e,
    input  logic [31:0] pred_target_e,
    output logic        flush_d,
    output logic        flush_e,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
);

    localparam int unsigned IDX = $clog2(ENTRIES);
    localparam int unsigned TW  = 30 - IDX;

    logic [ENTRIES-1:0] valid_q;
    logic [TW-1:0]      tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [1:0]         cnt_q    [ENTRIES];

    logic [IDX-1:0] f_idx;
    logic [TW-1:0]  f_tag;
    logic           hit_f;
    logic [IDX-1:0] e_idx;
    logic [TW-1:0]  e_tag;
    logic           hit_e;

    logic        br_upd;
    logic        mis_branch;
    logic        mis_alias;
    logic        mispredict;
    logic [31:0] correct_pc;

    logic        pend_valid_q;
    logic [31:0] pend_pc_q;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc_f[1:0], pc_e[1:0]};

    // Fetch-side lookup
    assign f_idx = pc_f[IDX+1:2];
    assign f_tag = pc_f[31:IDX+2];
    assign hit_f = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

    assign pred_taken_f  = hit_f && cnt_q[f_idx][1];
    assign pred_target_f = hit_f ? target_q[f_idx] : pc_f + 32'd4;

    // Execute-side resolution
    assign e_idx = pc_e[IDX+1:2];
    assign e_tag = pc_e[31:IDX+2];
    assign hit_e = valid_q[e_idx] && (tag_q[e_idx] == e_tag);

    assign br_upd     = update_valid_e && is_branch_e;
    assign mis_branch = br_upd &&
                        ((taken_e != pred_taken_e) || (taken_e && (target_e != pred_target_e)));
    assign mis_alias  = update_valid_e && !is_branch_e && pred_taken_e;
    assign mispredict = mis_branch || mis_alias;
    assign correct_pc = (is_branch_e && taken_e) ? target_e : pc_e + 32'd4;

    assign flush_d = mispredict;
    assign flush_e = mispredict;

    always_comb begin
        pc_next = pred_target_f;
        if (mispredict)
            pc_next = correct_pc;
        else if (pend_valid_q)
            pc_next = pend_pc_q;
    end

    // A redirect raised under stall is parked until fetch can take it
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid_q <= 1'b0;
            pend_pc_q    <= '0;
        end else if (mispredict && stall_f) begin
            pend_valid_q <= 1'b1;
            pend_pc_q    <= correct_pc;
        end else if (!stall_f) begin
            pend_valid_q <= 1'b0;
        end
    end

    // Valid bits and counters carry reset state
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++)
                cnt_q[i] <= 2'b01;
        end else if (br_upd) begin
            if (hit_e) begin
                if (taken_e && cnt_q[e_idx] != 2'b11)
                    cnt_q[e_idx] <= cnt_q[e_idx] + 2'b01;
                else if (!taken_e && cnt_q[e_idx] != 2'b00)
                    cnt_q[e_idx] <= cnt_q[e_idx] - 2'b01;
            end else if (taken_e) begin
                valid_q[e_idx] <= 1'b1;
                cnt_q[e_idx]   <= 2'b10;
            end
        end else if (mis_alias && hit_e) begin
            valid_q[e_idx] <= 1'b0;
        end
    end

    // Tag/target payload is qualified by valid, so it needs no reset
    always_ff @(posedge clk) begin
        if (!reset && br_upd && taken_e) begin
            target_q[e_idx] <= target_e;
            if (!hit_e)
                tag_q[e_idx] <= e_tag;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] stat_br_q;
    logic [31:0] stat_mis_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_br_q  <= '0;
            stat_mis_q <= '0;
        end else begin
            if (br_upd && stat_br_q != '1)
                stat_br_q <= stat_br_q + 32'd1;
            if (mispredict && stat_mis_q != '1)
                stat_mis_q <= stat_mis_q + 32'd1;
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mis_q;
`else
    assign stat_branches    = '0;
    assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: expected outputs are queued at stimulus
// time and popped/compared once the combinational outputs have settled.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_f;
    logic        stall_f;
    logic [31:0] pc_next;
    logic        pred_taken_f;
    logic [31:0] pred_target_f;
    logic        update_valid_e;
    logic        is_branch_e;
    logic        taken_e;
    logic [31:0] pc_e;
    logic [31:0] target_e;
    logic        pred_taken_e;
    logic [31:0] pred_target_e;
    logic        flush_d;
    logic        flush_e;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string       name;
        logic [31:0] pcn;
        logic        pt;
        logic        fl;
        bit          chk_pcn;
    } exp_t;

    exp_t sb[$];

    branch_predictor #(.ENTRIES(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .pc_f             (pc_f),
        .stall_f          (stall_f),
        .pc_next          (pc_next),
        .pred_taken_f     (pred_taken_f),
        .pred_target_f    (pred_target_f),
        .update_valid_e   (update_valid_e),
        .is_branch_e      (is_branch_e),
        .taken_e          (taken_e),
        .pc_e             (pc_e),
        .target_e         (target_e),
        .pred_taken_e     (pred_taken_e),
        .pred_target_e    (pred_target_e),
        .flush_d          (flush_d),
        .flush_e          (flush_e),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string tg, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tg, obs, exp);
        end
    endtask

    task automatic idle_e();
        update_valid_e = 1'b0;
        is_branch_e    = 1'b0;
        taken_e        = 1'b0;
        pc_e           = 32'h0;
        target_e       = 32'h0;
        pred_taken_e   = 1'b0;
        pred_target_e  = 32'h0;
    endtask

    task automatic upd(input logic br, input logic tk, input logic [31:0] pce,
                       input logic [31:0] tgt, input logic ppt, input logic [31:0] ptg);
        update_valid_e = 1'b1;
        is_branch_e    = br;
        taken_e        = tk;
        pc_e           = pce;
        target_e       = tgt;
        pred_taken_e   = ppt;
        pred_target_e  = ptg;
    endtask

    // Advance to the next negedge with the execute stage idle
    task automatic tick();
        @(negedge clk);
        idle_e();
    endtask

    task automatic step(input string nm, input logic [31:0] pcn, input logic pt,
                        input logic fl, input bit chk_pcn);
        exp_t e;
        sb.push_back('{nm, pcn, pt, fl, chk_pcn});
        #1;
        e = sb.pop_front();
        if (e.chk_pcn)
            cmp({e.name, ".pc_next"}, pc_next, e.pcn);
        cmp({e.name, ".pred_taken_f"}, {31'b0, pred_taken_f}, {31'b0, e.pt});
        cmp({e.name, ".flush_d"}, {31'b0, flush_d}, {31'b0, e.fl});
        cmp({e.name, ".flush_e"}, {31'b0, flush_e}, {31'b0, e.fl});
    endtask

    initial begin
        reset = 1'b1; stall_f = 1'b0; pc_f = 32'h100; idle_e();
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        step("reset", 32'h104, 1'b0, 1'b0, 1'b1);
        cmp("reset.pred_target_f", pred_target_f, 32'h104);
        cmp("reset.stat_branches", stat_branches, 32'd0);
        cmp("reset.stat_mispredicts", stat_mispredicts, 32'd0);

        // Allocation; same-cycle lookup still sees the old (empty) entry
        tick(); upd(1'b1, 1'b1, 32'h100, 32'h40, 1'b0, 32'h104);
        step("alloc", 32'h40, 1'b0, 1'b1, 1'b1);
        tick();
        step("alloc_hit", 32'h40, 1'b1, 1'b0, 1'b1);

        // Two not-taken resolutions: 10 -> 01 -> 00
        tick(); upd(1'b1, 1'b0, 32'h100, 32'h40, 1'b1, 32'h40);
        step("nt1", 32'h104, 1'b1, 1'b1, 1'b1);
        tick(); upd(1'b1, 1'b0, 32'h100, 32'h40, 1'b0, 32'h104);
        step("nt2", 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        step("cnt00", 32'h0, 1'b0, 1'b0, 1'b0);

        // Three taken: 00 -> 01 -> 10 -> 11, lookup shows the pre-update counter
        tick(); upd(1'b1, 1'b1, 32'h100, 32'h40, 1'b1, 32'h40);
        step("t1", 32'h40, 1'b0, 1'b0, 1'b1);
        tick(); upd(1'b1, 1'b1, 32'h100, 32'h40, 1'b1, 32'h40);
        step("t2", 32'h40, 1'b0, 1'b0, 1'b1);
        tick(); upd(1'b1, 1'b1, 32'h100, 32'h40, 1'b1, 32'h40);
        step("t3", 32'h40, 1'b1, 1'b0, 1'b1);
        tick(); upd(1'b1, 1'b0, 32'h100, 32'h40, 1'b1, 32'h40);
        step("nt_from11", 32'h104, 1'b1, 1'b1, 1'b1);
        tick();
        step("hyst10", 32'h40, 1'b1, 1'b0, 1'b1);

        // Redirect raised under stall is held until stall drops
        tick(); stall_f = 1'b1; upd(1'b1, 1'b1, 32'h184, 32'h200, 1'b0, 32'h188);
        step("stall_mis", 32'h200, 1'b1, 1'b1, 1'b1);
        tick();
        step("stall_hold1", 32'h200, 1'b1, 1'b0, 1'b1);
        tick();
        step("stall_hold2", 32'h200, 1'b1, 1'b0, 1'b1);
        tick(); stall_f = 1'b0;
        step("stall_release", 32'h200, 1'b1, 1'b0, 1'b1);
        tick();
        step("post_release", 32'h40, 1'b1, 1'b0, 1'b1);

        // Alias: non-branch predicted taken invalidates the entry
        tick(); upd(1'b0, 1'b0, 32'h100, 32'h0, 1'b1, 32'h40);
        step("alias", 32'h104, 1'b1, 1'b1, 1'b1);
        tick();
        step("alias_miss", 32'h104, 1'b0, 1'b0, 1'b1);
        cmp("alias_miss.pred_target_f", pred_target_f, 32'h104);

        // 32-bit wrap of pc+4 on both the fetch and correction paths
        tick(); pc_f = 32'hFFFF_FFFC; upd(1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b0, 32'h0);
        step("wrap_fetch", 32'h0, 1'b0, 1'b0, 1'b1);
        tick(); upd(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b1, 32'h1234);
        step("wrap_correct", 32'h0, 1'b0, 1'b1, 1'b1);

        // Target mismatch under stall, then reset drops the pending redirect
        tick(); pc_f = 32'h184; stall_f = 1'b1; upd(1'b1, 1'b1, 32'h184, 32'h300, 1'b1, 32'h200);
        step("tgt_mis", 32'h300, 1'b1, 1'b1, 1'b1);
        tick();
        step("tgt_pend", 32'h300, 1'b1, 1'b0, 1'b1);
`ifdef BP_STATS_EN
        cmp("stat_branches", stat_branches, 32'd10);
        cmp("stat_mispredicts", stat_mispredicts, 32'd7);
`else
        cmp("stat_branches", stat_branches, 32'd0);
        cmp("stat_mispredicts", stat_mispredicts, 32'd0);
`endif
        reset = 1'b1;
        tick(); reset = 1'b0;
        step("reset_pend", 32'h188, 1'b0, 1'b0, 1'b1);
        cmp("reset_pend.stat_branches", stat_branches, 32'd0);
        cmp("reset_pend.stat_mispredicts", stat_mispredicts, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-stage next-PC generator that drives `pc_next` into the program counter register. It holds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, and predicts the next fetch address from the current `pc`. It resolves predictions against execute-stage outcomes, redirects fetch on a misprediction, and flushes the younger pipeline stages. A redirect that arrives while fetch is stalled is held until fetch can accept it.

## Interface
- `ENTRIES`, 16, number of BTB entries; power of two, 2 to 256.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `pc_f`  in  32  current fetch address (PC register output).
- `stall_f`  in  1  fetch stall; the PC register holds while high.
- `pc_next`  out  32  next fetch address into the PC register.
- `pred_taken_f`  out  1  prediction for `pc_f`; pipelined downstream with the instruction.
- `pred_target_f`  out  32  predicted target for `pc_f`; pipelined downstream.
- `update_valid_e`  in  1  execute-stage instruction valid; high for exactly one cycle per instruction.
- `is_branch_e`  in  1  execute instruction is a branch or jump.
- `taken_e`  in  1  resolved direction.
- `pc_e`  in  32  execute instruction address.
- `target_e`  in  32  resolved target.
- `pred_taken_e`, `pred_target_e`  in  1/32  prediction carried with the instruction.
- `flush_d`, `flush_e`  out  1  squash the decode and execute pipeline registers.
- `stat_branches`, `stat_mispredicts`  out  32  performance counters (see Configuration).

## Operation
- Index is `pc[IDX+1:2]` with IDX = log2(ENTRIES). Tag is `pc[31:IDX+2]`. Each entry holds valid, tag, target[31:0] and cnt[1:0].
- Lookup (combinational):
  - Hit means valid && tag match.
  - `pred_taken_f` = hit && cnt[1].
  - `pred_target_f` = entry target on a hit, else `pc_f+4`.
- Mispredict (combinational, requires `update_valid_e`):
  - Branch case: `is_branch_e` && (`taken_e` != `pred_taken_e` || (`taken_e` && `target_e` != `pred_target_e`)).
  - Alias case: !`is_branch_e` && `pred_taken_e`.
- Correct PC is `target_e` if `is_branch_e` && `taken_e`, else `pc_e+4`. All adds are 32-bit modulo; 0xFFFFFFFC+4 wraps to 0.
- `pc_next` priority:
  1. Mispredict this cycle → correct PC.
  2. Pending redirect register valid → pending PC.
  3. `pred_target_f`.
- `flush_d` = `flush_e` = mispredict this cycle. These outputs are not held during the pending period.
- Pending redirect:
  - Set when a mispredict occurs with `stall_f`=1; captures the correct PC.
  - Cleared on the first cycle with `stall_f`=0.
  - A newer mispredict overwrites it.
- BTB update on `update_valid_e` && `is_branch_e`:
  - Hit: cnt saturating-increments if taken, else saturating-decrements. If taken, target ← `target_e`.
  - Miss and taken: allocate (overwrite) the entry with valid=1, new tag, target, cnt=2'b10.
  - Miss and not taken: no change.
- BTB update on the alias case: clear the valid bit of the matching entry.
- Lookup and update at the same index in the same cycle: lookup sees the old contents; the update is visible from the next cycle.
- Reset:
  - All valid bits 0, all cnt 2'b01, pending cleared, stats 0.
  - After reset, `pc_next` = `pc_f+4`, `pred_taken_f` = 0 and flushes = 0.
  - Reset mid-pending drops the pending redirect.

## Timing
- Lookup and redirect are zero latency: `pc_next` settles combinationally from `pc_f` and the execute inputs in the same cycle.
- BTB, counter, pending and stats state changes on the rising `clk` edge only.
- Mispredict penalty is 2 cycles, squashing decode and execute.

## Configuration
- `BP_STATS_EN` defined:
  - `stat_branches` increments on each `update_valid_e` && `is_branch_e`.
  - `stat_mispredicts` increments on each mispredict (branch and alias cases).
  - Both saturate at 0xFFFFFFFF.
- `BP_STATS_EN` undefined: no counter registers are built, and both outputs are tied to 0.

## Test plan
- Reset, then `pc_f`=0x100 → `pc_next`=0x104, `pred_taken_f`=0, `flush_d`=0.
- Taken-branch allocation:
  - Stimulus: branch at `pc_e`=0x100, `taken_e`=1, `target_e`=0x40, predicted not taken.
  - Same cycle: `flush_d`=`flush_e`=1, `pc_next`=0x40.
  - Next cycle: `pc_f`=0x100 gives `pred_taken_f`=1 and `pc_next`=0x40.
- Counter hysteresis and saturation:
  - Two not-taken resolutions at 0x100 leave cnt=00 → `pred_taken_f`=0.
  - Three taken resolutions reach 11; one further not-taken leaves 10 → still predicts taken.
- Stalled redirect:
  - Mispredict to 0x200 with `stall_f`=1 for 3 cycles → `pc_next`=0x200 throughout.
  - First cycle with `stall_f`=0 → pending clears, and the following cycle shows normal prediction.
- Alias:
  - Stimulus: non-branch at 0x100 (indexed entry valid, `pred_taken_e`=1) → `pc_next`=0x104 and flush.
  - Entry invalidated: the next lookup of 0x100 misses.
- Stats with `BP_STATS_EN`: 5 branches with 2 mispredicts → `stat_branches`=5, `stat_mispredicts`=2. Without the macro both read 0.
